// File: rtl/scale_pkg.sv
// scale_pkg: shared definitions for the horizontal scaling coordinate generator.
//   STEP_FRAC_DEF   default fractional bits of step/accumulator (Q4.12)
//   FIX_ONE/HALF    fixed-point 1.0 and 0.5 at the default format
//   state_t         line FSM states
//   init_acc()      initial accumulator value for a line
// Optional feature macro: SCALE_CENTER_ALIGN_EN selects pixel-centre alignment
// (initial accumulator = step/2 - 0.5, floored at 0); when undefined the
// accumulator starts at 0 (corner alignment).
package scale_pkg;

  localparam int          STEP_FRAC_DEF = 12;
  localparam logic [31:0] FIX_ONE       = 32'd1 << STEP_FRAC_DEF;
  localparam logic [31:0] FIX_HALF      = 32'd1 << (STEP_FRAC_DEF - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

`ifdef SCALE_CENTER_ALIGN_EN
  localparam bit CENTER_ALIGN = 1'b1;
`else
  localparam bit CENTER_ALIGN = 1'b0;
`endif

  // frac is the number of fractional bits of the caller's fixed-point format.
  // Centre alignment offsets by half a destination pixel minus half a source
  // pixel; negative results (step < 1.0) floor at zero.
  function automatic logic [31:0] init_acc(input logic [31:0] step,
                                           input int unsigned frac);
    logic [31:0] half;
    logic [31:0] s2;
    half = 32'd1 << (frac - 1);
    s2   = step >> 1;
    if (!CENTER_ALIGN) return '0;
    return (s2 >= half) ? (s2 - half) : '0;
  endfunction

endpackage

// File: rtl/scale_coord_gen_if.sv
// scale_coord_gen_if: coordinate output stream (valid/ready).
//   out_valid    coordinate available (master -> slave)
//   out_ready    downstream accepts (slave -> master)
//   out_src_int  clamped source integer index
//   out_frac     interpolation weight
//   out_last     final coordinate of the line
interface scale_coord_gen_if #(
  parameter int COORD_W = 11,
  parameter int FRAC_W  = 4
) ();

  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] out_src_int;
  logic [FRAC_W-1:0]  out_frac;
  logic               out_last;

  modport master (
    output out_valid, out_src_int, out_frac, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_src_int, out_frac, out_last,
    output out_ready
  );

endinterface

// File: rtl/scale_acc_sat.sv
// scale_acc_sat: saturating source-position accumulator with registered
// int/frac extraction.
//   clk, rst_n   clock, async active-low reset
//   load         load accumulator with load_val (has priority over add)
//   load_val     initial accumulator value
//   add          advance accumulator by step, saturating at all-ones
//   step         unsigned fixed-point step (STEP_FRAC fractional bits)
//   src_max      clamp limit for the integer index
//   src_int      registered clamped integer index
//   frac         registered interpolation weight (MSBs of fraction)
// FRAC_W must not exceed STEP_FRAC.
module scale_acc_sat import scale_pkg::*; #(
  parameter  int COORD_W   = 11,
  parameter  int FRAC_W    = 4,
  parameter  int STEP_W    = 16,
  parameter  int STEP_FRAC = STEP_FRAC_DEF,
  localparam int ACC_W     = COORD_W + STEP_FRAC + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [ACC_W-1:0]   load_val,
  input  logic               add,
  input  logic [STEP_W-1:0]  step,
  input  logic [COORD_W-1:0] src_max,
  output logic [COORD_W-1:0] src_int,
  output logic [FRAC_W-1:0]  frac
);

  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_nxt;
  logic [ACC_W-1:0]   acc_add;
  logic [ACC_W:0]     acc_sum;
  logic [COORD_W-1:0] int_raw;
  logic [COORD_W-1:0] int_nxt;
  logic [FRAC_W-1:0]  frac_nxt;
  logic               clamp;

  always_comb begin
    // One extra bit catches the carry so the sum pins at all-ones instead of
    // wrapping back to a small source index.
    acc_sum = {1'b0, acc} + (ACC_W+1)'(step);
    acc_add = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];

    acc_nxt = acc;
    if (load)     acc_nxt = load_val;
    else if (add) acc_nxt = acc_add;

    // Extraction runs on the next value so src_int/frac are registered
    // alongside acc and appear in the same cycle as the coordinate's valid.
    int_raw  = acc_nxt[STEP_FRAC +: COORD_W];
    clamp    = acc_nxt[ACC_W-1] | (int_raw > src_max);
    int_nxt  = clamp ? src_max : int_raw;
    frac_nxt = clamp ? '0 : acc_nxt[STEP_FRAC-1 -: FRAC_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      src_int <= '0;
      frac    <= '0;
    end else begin
      acc     <= acc_nxt;
      src_int <= int_nxt;
      frac    <= frac_nxt;
    end
  end

endmodule

// File: rtl/scale_coord_gen.sv
// scale_coord_gen: runtime-programmable horizontal scaling coordinate
// generator. On start, streams one (source index, weight) pair per accepted
// cycle for each of dst_len destination columns.
//   clk, rst_n   clock, async active-low reset
//   start        begin a line (ignored unless idle)
//   step         source advance per destination column (Q(STEP_W-STEP_FRAC).STEP_FRAC)
//   dst_len      destination columns to emit (0 = immediate done)
//   src_max      highest legal source index
//   busy         line in progress (accepted start .. final transfer)
//   done         one-cycle pulse at line completion
//   coord        output stream (scale_coord_gen_if master)
// Optional feature macro: SCALE_CENTER_ALIGN_EN (see scale_pkg::init_acc).
module scale_coord_gen import scale_pkg::*; #(
  parameter int COORD_W   = 11,
  parameter int FRAC_W    = 4,
  parameter int STEP_W    = 16,
  parameter int STEP_FRAC = STEP_FRAC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [STEP_W-1:0]  step,
  input  logic [COORD_W-1:0] dst_len,
  input  logic [COORD_W-1:0] src_max,
  output logic               busy,
  output logic               done,
  scale_coord_gen_if.master  coord
);

  localparam int ACC_W  = COORD_W + STEP_FRAC + 1;
  localparam int STAGES = 1;

  state_t             state, state_nxt;
  logic               accept;
  logic               accept_zero;
  logic               xfer;
  logic               line_end;
  logic               acc_add_en;
  logic [STAGES:0]    vld_pipe;
  logic [STEP_W-1:0]  step_q;
  logic [COORD_W-1:0] len_q;
  logic [COORD_W-1:0] smax_q;
  logic [COORD_W-1:0] smax_sel;
  logic [COORD_W-1:0] cnt;
  logic [COORD_W-1:0] cnt_inc;
  logic               last_q;
  logic [ACC_W-1:0]   acc_init;

  assign coord.out_valid = vld_pipe[STAGES];
  assign coord.out_last  = last_q;

  assign acc_init = ACC_W'(init_acc(32'(step), STEP_FRAC));
  assign cnt_inc  = cnt + COORD_W'(1);

  // Use the live src_max on the load cycle; the latched copy is not yet valid.
  assign smax_sel = accept ? src_max : smax_q;

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    accept_zero = 1'b0;
    xfer        = vld_pipe[STAGES] & coord.out_ready;
    line_end    = xfer & last_q;
    // The final beat does not advance: the accumulator just rests.
    acc_add_en  = xfer & ~last_q;
    case (state)
      IDLE: begin
        if (start) begin
          if (dst_len != '0) begin
            accept    = 1'b1;
            state_nxt = RUN;
          end else begin
            accept_zero = 1'b1;
          end
        end
      end
      RUN: begin
        if (line_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // vld_pipe[0] is the cycle spent loading the accumulator; the first
  // coordinate then appears one edge later, held until the last transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      step_q   <= '0;
      len_q    <= '0;
      smax_q   <= '0;
      cnt      <= '0;
      last_q   <= 1'b0;
    end else begin
      vld_pipe[0]      <= accept;
      vld_pipe[STAGES] <= vld_pipe[0] | (vld_pipe[STAGES] & ~line_end);
      busy             <= accept | (busy & ~line_end);
      done             <= accept_zero | line_end;
      if (accept) begin
        step_q <= step;
        len_q  <= dst_len;
        smax_q <= src_max;
        cnt    <= '0;
      end
      if (vld_pipe[0]) begin
        last_q <= (len_q == COORD_W'(1));
      end else if (xfer) begin
        cnt    <= cnt_inc;
        last_q <= ~last_q & (cnt_inc == len_q - COORD_W'(1));
      end
    end
  end

  scale_acc_sat #(
    .COORD_W  (COORD_W),
    .FRAC_W   (FRAC_W),
    .STEP_W   (STEP_W),
    .STEP_FRAC(STEP_FRAC)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .load_val(acc_init),
    .add     (acc_add_en),
    .step    (step_q),
    .src_max (smax_sel),
    .src_int (coord.out_src_int),
    .frac    (coord.out_frac)
  );

endmodule

// File: tb/tb_scale_coord_gen.sv
// tb_scale_coord_gen: scoreboard bench for scale_coord_gen. Expected beats
// come from a closed-form model (init + k*step, saturated) pushed when a
// line is started and popped on each transfer.
module tb_scale_coord_gen;
  import scale_pkg::*;

  localparam int COORD_W   = 11;
  localparam int FRAC_W    = 4;
  localparam int STEP_W    = 16;
  localparam int STEP_FRAC = 12;
  localparam longint ACC_MAX = (longint'(1) << (COORD_W + STEP_FRAC + 1)) - 1;
  localparam longint GUARD   = longint'(1) << (COORD_W + STEP_FRAC);

`ifdef SCALE_CENTER_ALIGN_EN
  localparam bit CTR = 1'b1;
`else
  localparam bit CTR = 1'b0;
`endif

  typedef struct {
    int src_int;
    int frac;
    int last;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [STEP_W-1:0]  step;
  logic [COORD_W-1:0] dst_len;
  logic [COORD_W-1:0] src_max;
  logic               busy;
  logic               done;

  scale_coord_gen_if #(.COORD_W(COORD_W), .FRAC_W(FRAC_W)) oif ();

  scale_coord_gen #(
    .COORD_W(COORD_W), .FRAC_W(FRAC_W), .STEP_W(STEP_W), .STEP_FRAC(STEP_FRAC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .dst_len(dst_len),
    .src_max(src_max), .busy(busy), .done(done), .coord(oif)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];
  bit   mon_en = 1'b1;
  int   xfers = 0;
  int   stall_beat = -1;
  int   stall_rem = 0;
  bit   poke_arm = 1'b0;
  bit   poke_clr = 1'b0;
  bit   prev_stalled = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint model_init(input longint stp);
    longint s2;
    s2 = stp >> 1;
    if (!CTR) return 0;
    return (s2 >= longint'(FIX_HALF)) ? s2 - longint'(FIX_HALF) : 0;
  endfunction

  function automatic exp_t model_beat(input longint init, input longint stp,
                                      input int k, input int smax, input int len);
    exp_t   e;
    longint a;
    int     ip;
    a = init + longint'(k) * stp;
    if (a > ACC_MAX) a = ACC_MAX;
    ip = int'((a >> STEP_FRAC) & ((1 << COORD_W) - 1));
    if (a >= GUARD || ip > smax) begin
      e.src_int = smax;
      e.frac    = 0;
    end else begin
      e.src_int = ip;
      e.frac    = int'((a >> (STEP_FRAC - FRAC_W)) & ((1 << FRAC_W) - 1));
    end
    e.last = (k == len - 1) ? 1 : 0;
    return e;
  endfunction

  // Ready control, start poke during a stall, and output comparison.
  // Ready set here applies to the following rising edge.
  always @(negedge clk) begin
    if (poke_clr) begin
      start    = 1'b0;
      poke_clr = 1'b0;
    end
    if (mon_en) begin
      if (oif.out_valid && xfers == stall_beat && stall_rem > 0) begin
        oif.out_ready = 1'b0;
        stall_rem--;
        if (poke_arm) begin
          start    = 1'b1;
          step     = 16'h3000;
          dst_len  = 11'd2;
          poke_arm = 1'b0;
          poke_clr = 1'b1;
        end
      end else begin
        oif.out_ready = 1'b1;
      end
      if (oif.out_valid) begin
        if (q.size() == 0) begin
          chk("valid_unexpected", oif.out_valid, 0);
        end else begin
          chk("src_int", oif.out_src_int, q[0].src_int);
          chk("frac",    oif.out_frac,    q[0].frac);
          chk("last",    oif.out_last,    q[0].last);
          if (oif.out_ready) begin
            void'(q.pop_front());
            xfers++;
          end else begin
            chk("busy_stall", busy, 1);
          end
        end
      end else if (prev_stalled) begin
        chk("valid_drop", oif.out_valid, 1);
      end
      prev_stalled = oif.out_valid && !oif.out_ready;
    end
  end

  task automatic run_line(input int stp, input int len, input int smax,
                          input int stall_b, input int stall_n);
    longint init;
    int     n;
    init = model_init(stp);
    for (int k = 0; k < len; k++) q.push_back(model_beat(init, stp, k, smax, len));
    xfers      = 0;
    stall_beat = stall_b;
    stall_rem  = stall_n;
    poke_arm   = (stall_n > 0);
    @(posedge clk); #1;
    start   = 1'b1;
    step    = STEP_W'(stp);
    dst_len = COORD_W'(len);
    src_max = COORD_W'(smax);
    @(posedge clk); #1;
    n     = cyc;
    start = 1'b0;
    @(negedge clk);
    chk("busy_rise", busy, (len != 0) ? 1 : 0);
    chk("valid_first_cycle", oif.out_valid, 0);
    for (int i = 0; i < len + stall_n + 10 && !done; i++) @(negedge clk);
    chk("done_seen", done, 1);
    if (done) begin
      chk("done_cycle", cyc, (len == 0) ? n : n + 1 + len + stall_n);
      chk("busy_fall", busy, 0);
      chk("valid_fall", oif.out_valid, 0);
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("queue_empty", q.size(), 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    step          = '0;
    dst_len       = '0;
    src_max       = '0;
    oif.out_ready = 1'b1;
    #23;
    chk("rst_valid", oif.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_int", oif.out_src_int, 0);
    chk("rst_frac", oif.out_frac, 0);
    chk("rst_last", oif.out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_line(32'h1000, 4, 1023, -1, 0);
    run_line(32'h0800, 4, 1023, -1, 0);
    run_line(32'h4000, 4, 5, -1, 0);
    run_line(32'h2000, 3, 1023, -1, 0);
    run_line(32'hFFFF, 300, 2047, -1, 0);
    run_line(32'h1000, 6, 1023, 1, 3);
    run_line(32'h1000, 0, 100, -1, 0);
    run_line(32'h0000, 3, 1023, -1, 0);
    run_line(32'h1800, 1, 1023, -1, 0);

    // Reset while the second beat is on the bus.
    mon_en = 1'b0;
    @(posedge clk); #1;
    start   = 1'b1;
    step    = 16'h1000;
    dst_len = 11'd8;
    src_max = 11'd1023;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_valid", oif.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", oif.out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_int", oif.out_src_int, 0);
    chk("mid_rst_frac", oif.out_frac, 0);
    chk("mid_rst_last", oif.out_last, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid_rst_done", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    q.delete();
    prev_stalled = 1'b0;
    mon_en       = 1'b1;

    run_line(32'h1000, 5, 1023, -1, 0);
    run_line(32'h0800, 3, 1023, -1, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
